// File: rtl/data_route_pkg.sv
// Shared constants and state encoding for the data-route width converters.
package data_route_pkg;

  // Input beat width in bits.
  localparam int IN_W  = 128;
  // Number of input beats that are packed into one output word.
  localparam int RATIO = 12;
  // Width of the packed output word. It is derived from the two values above.
  localparam int OUT_W = IN_W * RATIO;
  // Width of the beat counter. 2**CNT_W must be larger than RATIO.
  localparam int CNT_W = 4;

  // Accumulator-side state.
  // FILL: input beats are accepted.
  // PEND: a finished word is parked in the accumulator until the output register frees up.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } pack_state_t;

endpackage

// File: rtl/in128_out1536.sv
// Width up-converter: packs RATIO consecutive IN_W-bit AXI-Stream beats into one
// OUT_W-bit word. A word is closed early by s_axis_tlast; unused beat slots read
// as zero. The accumulator and the output register form a two-deep buffer, so
// input keeps flowing while a finished word waits for the downstream side.
module in128_out1536
  import data_route_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] m_axis_tbeats,
  input  logic             m_axis_tready
);

  // Accumulator-side state and beat counter.
  pack_state_t      state_reg;
  pack_state_t      state_next;
  logic [CNT_W-1:0] cnt_reg;

  // Side information for a finished word that is parked in the accumulator.
  logic             pend_last_reg;
  logic [CNT_W-1:0] pend_beats_reg;

  // Output register.
  logic [OUT_W-1:0] out_data_reg;
  logic             out_last_reg;
  logic [CNT_W-1:0] out_beats_reg;
  logic             out_valid_reg;

  // Handshakes and word completion.
  logic             in_fire;
  logic             out_fire;
  logic             at_last_slot;
  logic             word_done;

  // Control decoded by the FSM.
  logic             load_out;
  logic             acc_clear;
  logic             pend_capture;
  logic             load_last;
  logic [CNT_W-1:0] load_beats;

  // Per-slot write enables, and the accumulator contents with the current beat merged in.
  logic [RATIO-1:0] slot_wr;
  logic [OUT_W-1:0] merged_word;

  // Input is only accepted while filling. It is also held low while reset is asserted.
  assign s_axis_tready = rst_n && (state_reg == ST_FILL);
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign out_fire      = out_valid_reg && m_axis_tready;
  assign at_last_slot  = (cnt_reg == CNT_W'(RATIO - 1));
  assign word_done     = in_fire && (at_last_slot || s_axis_tlast);

  // Each beat slot is an enable-gated register bank. The slot is selected by
  // decoding cnt, so no wide shifter sits in the datapath. The merged view lets
  // the completing beat go straight into the output register.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
      logic [IN_W-1:0] slot_reg;

      assign slot_wr[gi] = in_fire && (cnt_reg == CNT_W'(gi));
      assign merged_word[gi*IN_W +: IN_W] = slot_wr[gi] ? s_axis_tdata : slot_reg;

      // Slot storage: cleared whenever a word leaves the accumulator; written when its beat arrives.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (acc_clear) begin
          slot_reg <= '0;
        end else if (slot_wr[gi]) begin
          slot_reg <= s_axis_tdata;
        end
      end
    end
  endgenerate

  // Next-state and datapath control for the accumulator side.
  always_comb begin
    state_next   = state_reg;
    load_out     = 1'b0;
    acc_clear    = 1'b0;
    pend_capture = 1'b0;
    case (state_reg)
      ST_FILL: begin
        if (word_done) begin
          if (!out_valid_reg || out_fire) begin
            // The output register is free now or is freed on this edge.
            load_out  = 1'b1;
            acc_clear = 1'b1;
          end else begin
            // The output register is busy. Keep the finished word in the accumulator.
            pend_capture = 1'b1;
            state_next   = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (out_fire) begin
          load_out   = 1'b1;
          acc_clear  = 1'b1;
          state_next = ST_FILL;
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  // Side information for the word that is loaded into the output register.
  // In PEND no beat can arrive, so merged_word already equals the parked word.
  assign load_last  = (state_reg == ST_PEND) ? pend_last_reg  : s_axis_tlast;
  assign load_beats = (state_reg == ST_PEND) ? pend_beats_reg : cnt_reg + CNT_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Beat counter: advances on each non-completing beat; returns to 0 when the accumulator empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (acc_clear) begin
      cnt_reg <= '0;
    end else if (in_fire && !word_done) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Remember tlast and the beat count of a word that had to be parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_last_reg  <= 1'b0;
      pend_beats_reg <= '0;
    end else if (pend_capture) begin
      pend_last_reg  <= s_axis_tlast;
      pend_beats_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Output register: loads a finished word, otherwise holds until it is handshaked away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_beats_reg <= '0;
      out_valid_reg <= 1'b0;
    end else if (load_out) begin
      out_data_reg  <= merged_word;
      out_last_reg  <= load_last;
      out_beats_reg <= load_beats;
      out_valid_reg <= 1'b1;
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tlast  = out_last_reg;
  assign m_axis_tbeats = out_beats_reg;
  assign m_axis_tvalid = out_valid_reg;

endmodule

// File: tb/tb_in128_out1536.sv
// Testbench for in128_out1536. It combines directed sequences, a small vector
// table and randomized traffic. All results are checked against a word-level
// reference model that keeps its finished words in a queue.
module tb_in128_out1536;
  import data_route_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [IN_W-1:0]  s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic [CNT_W-1:0] m_axis_tbeats;
  logic             m_axis_tready;

  in128_out1536 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tbeats (m_axis_tbeats),
    .m_axis_tready (m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One finished word as the model expects to see it at the output.
  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
    int               beats;
  } word_t;

  // Model state: words finished but not yet taken (at most two can be buffered),
  // plus the beats of the word currently being gathered.
  word_t           q[$];
  logic [IN_W-1:0] cur[$];

  int total = 0;
  int bad   = 0;
  int n_words = 0;

  // Compares two values of up to 64 bits and reports a failure on one line.
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compares two full words. On a mismatch only the first differing slot is printed.
  task automatic chk_word(string name, logic [OUT_W-1:0] act, logic [OUT_W-1:0] exp);
    int first;
    total++;
    if (act !== exp) begin
      bad++;
      first = 0;
      for (int k = RATIO - 1; k >= 0; k--)
        if (act[k*IN_W +: IN_W] !== exp[k*IN_W +: IN_W]) first = k;
      $display("FAIL %s slot %0d: got %h expected %h", name, first,
               act[first*IN_W +: IN_W], exp[first*IN_W +: IN_W]);
    end
  endtask

  // Runs one clock cycle. Before the edge, the DUT outputs are checked against
  // the model; after the edge, the model is advanced. Returns 1 in in_acc if
  // the input beat was accepted.
  task automatic cycle(output bit in_acc);
    bit    out_acc;
    word_t w;
    @(negedge clk);
    chk("s_ready", s_axis_tready, q.size() < 2);
    chk("m_valid", m_axis_tvalid, q.size() != 0);
    if (q.size() != 0) begin
      chk_word("m_data", m_axis_tdata, q[0].data);
      chk("m_last", m_axis_tlast, q[0].last);
      chk("m_beats", m_axis_tbeats, q[0].beats);
    end
    in_acc  = s_axis_tvalid && (q.size() < 2);
    out_acc = (q.size() != 0) && m_axis_tready;
    @(posedge clk);
    if (out_acc) begin
      $display("word %0d out: beats=%0d last=%0d", n_words, q[0].beats, q[0].last);
      void'(q.pop_front());
      n_words++;
    end
    if (in_acc) begin
      cur.push_back(s_axis_tdata);
      if (s_axis_tlast || cur.size() == RATIO) begin
        w.data = '0;
        foreach (cur[k]) w.data[k*IN_W +: IN_W] = cur[k];
        w.last  = s_axis_tlast;
        w.beats = cur.size();
        q.push_back(w);
        cur.delete();
      end
    end
    #1;
  endtask

  // Drives one beat. The beat data is four copies of a 32-bit tag.
  task automatic beat(input logic [31:0] tag, input bit last, output bit acc);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {4{tag}};
    s_axis_tlast  = last;
    cycle(acc);
  endtask

  // Closes any partial word with a tlast beat, then drains all buffered words
  // within a bounded number of cycles.
  task automatic drain();
    bit acc;
    int guard;
    m_axis_tready = 1'b1;
    guard = 0;
    while (cur.size() != 0 && guard < 20) begin
      beat(32'hdead_0000 + guard, 1'b1, acc);
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cycle(acc);
      guard++;
    end
    chk("drain_empty", q.size() + cur.size(), 0);
  endtask

  typedef struct {
    bit vld;
    bit last;
    bit mrdy;
    bit exp_mvalid;
    bit exp_sready;
    int exp_beats;
    bit exp_mlast;
  } row_t;

  row_t tbl[7];

  initial begin
    bit acc;
    int sent;
    int w0;
    int guard;

    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    // Check the reset state while reset is held low.
    #12;
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_s_ready", s_axis_tready, 0);
    chk_word("rst_m_data", m_axis_tdata, '0);
    chk("rst_m_last", m_axis_tlast, 0);
    chk("rst_m_beats", m_axis_tbeats, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 1: twelve beats tagged k form one word; tvalid rises just after beat 11.
    m_axis_tready = 1'b1;
    for (int k = 0; k < RATIO; k++) begin
      beat(k, 1'b0, acc);
      chk("t1_valid", m_axis_tvalid, (k == RATIO - 1));
    end
    for (int k = 0; k < RATIO; k++)
      chk("t1_slot", m_axis_tdata[k*IN_W +: 64], {2{32'(k)}});
    chk("t1_beats", m_axis_tbeats, 12);
    chk("t1_last", m_axis_tlast, 0);
    drain();

    // Test 2: 24 beats back to back with m_axis_tready high give two words.
    w0 = n_words;
    for (int k = 0; k < 2 * RATIO; k++) beat(32'h2000 + k, 1'b0, acc);
    drain();
    chk("t2_words", n_words - w0, 2);

    // Test 3: hold m_axis_tready low for 40 cycles while 30 beats are offered.
    m_axis_tready = 1'b0;
    sent = 0;
    w0 = n_words;
    for (int c = 0; c < 40; c++) begin
      if (sent < 30) begin
        beat(32'h3000 + sent, 1'b0, acc);
        if (acc) sent++;
      end else begin
        s_axis_tvalid = 1'b0;
        cycle(acc);
      end
    end
    chk("t3_held_beats", sent, 24);
    chk("t3_no_words", n_words - w0, 0);
    m_axis_tready = 1'b1;
    guard = 0;
    while (sent < 30 && guard < 40) begin
      beat(32'h3000 + sent, 1'b0, acc);
      if (acc) sent++;
      guard++;
    end
    chk("t3_all_beats", sent, 30);
    drain();
    chk("t3_words", n_words - w0, 3);

    // Test 4: tlast on beat index 4, followed by a two-beat word (vector table).
    tbl[0] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[3] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[4] = '{1, 1, 1, 1, 1, 5, 1};
    tbl[5] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[6] = '{1, 1, 1, 1, 1, 2, 1};
    for (int i = 0; i < 7; i++) begin
      s_axis_tvalid = tbl[i].vld;
      s_axis_tdata  = {4{32'h4000 + i}};
      s_axis_tlast  = tbl[i].last;
      m_axis_tready = tbl[i].mrdy;
      cycle(acc);
      chk("t4_m_valid", m_axis_tvalid, tbl[i].exp_mvalid);
      chk("t4_s_ready", s_axis_tready, tbl[i].exp_sready);
      if (tbl[i].exp_mvalid) begin
        chk("t4_beats", m_axis_tbeats, tbl[i].exp_beats);
        chk("t4_last", m_axis_tlast, tbl[i].exp_mlast);
        chk("t4_hi_zero", 64'(|(m_axis_tdata >> (tbl[i].exp_beats * IN_W))), 0);
        chk("t4_slot0", m_axis_tdata[63:0], {2{32'h4000 + i + 1 - tbl[i].exp_beats}});
      end
    end
    drain();

    // Test 5: beat 11 is accepted on the same cycle that a full output register is handshaked.
    m_axis_tready = 1'b0;
    for (int k = 0; k < RATIO; k++) beat(32'h5000 + k, 1'b0, acc);
    for (int k = 0; k < RATIO - 1; k++) beat(32'h5100 + k, 1'b0, acc);
    m_axis_tready = 1'b1;
    beat(32'h51ff, 1'b0, acc);
    chk("t5_accepted", acc, 1);
    chk("t5_m_valid", m_axis_tvalid, 1);
    chk("t5_s_ready", s_axis_tready, 1);
    chk("t5_slot11", m_axis_tdata[11*IN_W +: 64], {2{32'h51ff}});
    drain();

    // Test 6: reset with a pending word and a partial word; then a clean word.
    m_axis_tready = 1'b0;
    for (int k = 0; k < RATIO + 7; k++) beat(32'h6000 + k, 1'b0, acc);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_m_valid", m_axis_tvalid, 0);
    chk("t6_s_ready", s_axis_tready, 0);
    chk_word("t6_m_data", m_axis_tdata, '0);
    q.delete();
    cur.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_axis_tready = 1'b1;
    for (int k = 0; k < RATIO; k++) beat(32'h6100 + k, 1'b0, acc);
    chk("t6_m_valid_new", m_axis_tvalid, 1);
    chk("t6_slot0_new", m_axis_tdata[63:0], {2{32'h6100}});
    drain();

    // Randomized traffic checked against the model.
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tlast  = ($urandom_range(0, 9) == 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
